// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and destination resolution.
// Optional hazard-bubble counter is enabled by defining IDEX_BUBBLE_COUNT_EN.
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_reg_dst,
    input  logic              id_jump,
    input  logic              id_jal,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [2:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_jump,
    output logic              ex_jal,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [2:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
`ifdef IDEX_BUBBLE_COUNT_EN
    input  logic              count_clr,
    output logic [15:0]       bubble_count,
`endif
    output logic              hazard_stall
);

    logic              rawHazard;
    logic              loadBubble;
    logic [REG_AW-1:0] writeRegNext;

    // A load into $0 produces nothing to wait for, so it never stalls.
    always_comb begin
        rawHazard = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
        hazard_stall = rawHazard && !flush;
        loadBubble   = flush || hazard_stall || !id_valid;
        if (id_jal)
            writeRegNext = REG_AW'(LINK_REG);
        else if (id_reg_dst)
            writeRegNext = id_rd;
        else
            writeRegNext = id_rt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_jump       <= 1'b0;
            ex_jal        <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
        end else begin
            // Data and specifiers always load; only control is squashed in a bubble.
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_write_reg <= writeRegNext;
            ex_rd1       <= id_rd1;
            ex_rd2       <= id_rd2;
            ex_imm       <= id_imm;
            ex_pc4       <= id_pc4;
            if (loadBubble) begin
                ex_valid      <= 1'b0;
                ex_jump       <= 1'b0;
                ex_jal        <= 1'b0;
                ex_branch     <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_alu_op     <= '0;
            end else begin
                ex_valid      <= 1'b1;
                ex_jump       <= id_jump;
                ex_jal        <= id_jal;
                ex_branch     <= id_branch;
                ex_mem_read   <= id_mem_read;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_mem_write  <= id_mem_write;
                ex_alu_src    <= id_alu_src;
                ex_reg_write  <= id_reg_write;
                ex_alu_op     <= id_alu_op;
            end
        end
    end

`ifdef IDEX_BUBBLE_COUNT_EN
    // Counts only load-use bubbles; hazard_stall is already masked by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_count <= '0;
        else if (count_clr)
            bubble_count <= '0;
        else if (hazard_stall && (bubble_count != 16'hFFFF))
            bubble_count <= bubble_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; define IDEX_BUBBLE_COUNT_EN to also exercise the bubble counter.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_reg_dst, id_jump, id_jal, id_branch, id_mem_read;
    logic        id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [2:0]  id_alu_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic        flush;
    logic        ex_valid, ex_jump, ex_jal, ex_branch, ex_mem_read;
    logic        ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic        hazard_stall;
`ifdef IDEX_BUBBLE_COUNT_EN
    logic        count_clr;
    logic [15:0] bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
        .id_jump(id_jump), .id_jal(id_jal), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_jal(ex_jal),
        .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_write_reg(ex_write_reg), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4),
`ifdef IDEX_BUBBLE_COUNT_EN
        .count_clr(count_clr), .bubble_count(bubble_count),
`endif
        .hazard_stall(hazard_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_reg_dst = 0; id_jump = 0; id_jal = 0; id_branch = 0;
        id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0;
        id_reg_write = 0; id_alu_op = 3'b000; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_pc4 = 0; flush = 0;
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        idle();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1;
        id_reg_write = 1; id_rs = rs; id_rt = rt; id_imm = 32'h4;
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        idle();
        id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 3'b010;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rd1 = 32'h11; id_rd2 = 32'h22;
    endtask

    initial begin
        idle();
`ifdef IDEX_BUBBLE_COUNT_EN
        count_clr = 0;
`endif
        reset = 1;
        #3;
        chk("rst_valid", ex_valid, 0);
        chk("rst_wreg", ex_write_reg, 0);
        chk("rst_stall", hazard_stall, 0);
        #10 reset = 0;

        // R-type capture
        rtype(5'd8, 5'd9, 5'd10);
        step();
        chk("r_valid", ex_valid, 1);
        chk("r_wreg", ex_write_reg, 10);
        chk("r_aluop", ex_alu_op, 3'b010);
        chk("r_rd1", ex_rd1, 32'h11);
        chk("r_rd2", ex_rd2, 32'h22);
        chk("r_regwrite", ex_reg_write, 1);

        // Load-use: one bubble, then capture
        lw(5'd8, 5'd9);
        step();
        chk("lw_memread", ex_mem_read, 1);
        chk("lw_wreg", ex_write_reg, 9);
        rtype(5'd9, 5'd10, 5'd11);
        #1;
        chk("lu_stall", hazard_stall, 1);
        step();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_regwrite", ex_reg_write, 0);
        chk("lu_stall_clear", hazard_stall, 0);
`ifdef IDEX_BUBBLE_COUNT_EN
        chk("lu_count", bubble_count, 1);
`endif
        step();
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_wreg", ex_write_reg, 11);

        // Load to $0 then use of $0: no stall
        lw(5'd8, 5'd0);
        step();
        rtype(5'd0, 5'd0, 5'd12);
        #1;
        chk("z_stall", hazard_stall, 0);
        step();
        chk("z_valid", ex_valid, 1);

        // Load then non-matching use
        lw(5'd8, 5'd9);
        step();
        rtype(5'd5, 5'd6, 5'd7);
        #1;
        chk("nm_stall", hazard_stall, 0);
        step();
        chk("nm_valid", ex_valid, 1);

        // Flush beats hazard
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd3, 5'd4);
        flush = 1;
        #1;
        chk("fl_stall", hazard_stall, 0);
        step();
        chk("fl_valid", ex_valid, 0);
        chk("fl_regwrite", ex_reg_write, 0);
`ifdef IDEX_BUBBLE_COUNT_EN
        chk("fl_count", bubble_count, 1);
`endif

        // Store/branch style fields
        idle();
        id_valid = 1; id_branch = 1; id_mem_write = 1; id_alu_src = 1;
        id_imm = 32'hFFFF_FFF0; id_pc4 = 32'h0000_0104; id_rt = 5'd6;
        step();
        chk("sb_branch", ex_branch, 1);
        chk("sb_memwrite", ex_mem_write, 1);
        chk("sb_imm", ex_imm, 32'hFFFF_FFF0);
        chk("sb_pc4", ex_pc4, 32'h0000_0104);

        // jal resolves to link register
        idle();
        id_valid = 1; id_jal = 1; id_jump = 1; id_reg_write = 1;
        step();
        chk("jal_wreg", ex_write_reg, 31);
        chk("jal_jal", ex_jal, 1);
        chk("jal_valid", ex_valid, 1);

        // Mid-cycle async reset with ex_valid = 1
        #2 reset = 1;
        #1;
        chk("ar_valid", ex_valid, 0);
        chk("ar_wreg", ex_write_reg, 0);
        chk("ar_jump", ex_jump, 0);
        chk("ar_regwrite", ex_reg_write, 0);
        chk("ar_stall", hazard_stall, 0);
`ifdef IDEX_BUBBLE_COUNT_EN
        chk("ar_count", bubble_count, 0);
`endif
        #3 reset = 0;

        // Idle ID produces a bubble after reset release capture
        rtype(5'd1, 5'd2, 5'd3);
        step();
        chk("post_rst_valid", ex_valid, 1);
        idle();
        step();
        chk("idle_valid", ex_valid, 0);

`ifdef IDEX_BUBBLE_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            lw(5'd8, 5'd9);
            step();
            rtype(5'd2, 5'd9, 5'd3);
            step();
            step();
        end
        chk("cnt3", bubble_count, 3);
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd2, 5'd3);
        count_clr = 1;
        step();
        count_clr = 0;
        chk("cnt_clr", bubble_count, 0);
        chk("cnt_clr_bub", ex_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
